switch_port_arbiter: RTL

//  Packet-level round-robin arbiter sharing one switch output port between
//  NUM_PORTS input ports. Locks grant to one input from first beat to EOP,

---
 rtl/switch_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/switch_port_arbiter.sv
// Packet-level round-robin arbiter for one switch egress port.
// A grant is locked to one ingress port from the first beat of a packet until
// its EOP beat. Beats pass through combinationally from the granted port.
// A watchdog releases the grant when a packet runs MAX_BEATS beats without EOP.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no grant held; pick next requester scanning from rr_ptr
//   XFER  | grant locked to gnt; beats flow until EOP or watchdog release
module switch_port_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int DATA_W    = 8,
  parameter  int MAX_BEATS = 64,
  localparam int SRC_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS-1:0]          in_eop,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic                          out_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_eop,
  input  logic                          out_ready,
  output logic [SRC_W-1:0]              out_src,
  output logic                          wdog_err
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [SRC_W-1:0]   gnt, gnt_nxt;
  logic [SRC_W-1:0]   rr_ptr, rr_nxt;
  logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
  logic               wdog_nxt;

  logic               pick_vld;
  logic [SRC_W-1:0]   pick_idx;
  logic [SRC_W-1:0]   gnt_inc;
  logic               beat;

  // Round-robin pick: walk offsets from far to near so the port closest to
  // rr_ptr is the last (winning) assignment.
  always_comb begin : arb_pick
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = SRC_W'(cand);
      if (in_valid[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  assign gnt_inc = (gnt == SRC_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;

  // Output mux: granted port drives the egress port directly while in XFER.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_eop   = 1'b0;
    in_ready  = '0;
    out_src   = gnt;
    if (state == ST_XFER) begin
      out_valid     = in_valid[gnt];
      out_data      = in_data[int'(gnt)*DATA_W +: DATA_W];
      out_eop       = in_eop[gnt];
      in_ready[gnt] = out_ready;
    end
  end

  assign beat = out_valid & out_ready;

  // Next-state: grant on request in IDLE, release on EOP or watchdog limit.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr_ptr;
    cnt_nxt   = beat_cnt;
    wdog_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          gnt_nxt   = pick_idx;
          cnt_nxt   = '0;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        if (beat) begin
          if (out_eop) begin
            state_nxt = ST_IDLE;
            rr_nxt    = gnt_inc;
            cnt_nxt   = '0;
          end else if (beat_cnt == CNT_W'(MAX_BEATS - 1)) begin
            // Remaining beats of this packet come back as a fresh packet.
            state_nxt = ST_IDLE;
            rr_nxt    = gnt_inc;
            cnt_nxt   = '0;
            wdog_nxt  = 1'b1;
          end else if (beat_cnt != CNT_W'(MAX_BEATS)) begin
            cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      wdog_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
      wdog_err <= wdog_nxt;
    end
  end

endmodule
